// File: rtl/data_mem_responder.sv
// Fixed-latency data memory responder with a valid/ready request and response handshake.
// Define DMEM_MISALIGN_TRAP_EN to reject misaligned half/word accesses instead of aligning them down.
module data_mem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESP
   } state_t;

   state_t        r_state;
   state_t        w_nextState;
   logic [3:0]    r_cnt;

   logic          r_we;
   logic [1:0]    r_size;
   logic          r_unsigned;
   logic [31:0]   r_addr;
   logic [31:0]   r_wdata;
   logic [31:0]   r_rdata;
   logic          r_err;

   logic [31:0]   r_mem [DEPTH_WORDS];

   logic          w_accept;
   logic          w_done;
   logic          w_release;
   logic          w_oob;
   logic          w_sizeBad;
   logic          w_misalign;
   logic          w_err;
   logic [AW-1:0] w_idx;
   logic [1:0]    w_offs;
   logic [3:0]    w_byteEn;
   logic [31:0]   w_laneData;
   logic [31:0]   w_memWord;
   logic [31:0]   w_shifted;
   logic [31:0]   w_loadData;

   assign w_accept  = (r_state == IDLE) && req_valid;
   assign w_done    = (r_state == BUSY) && (r_cnt == 4'd0);
   assign w_release = (r_state == RESP) && resp_ready;

   // Everything below is decoded from the captured request, never the live inputs.
   assign w_oob     = (r_addr[31:2] >= 30'(DEPTH_WORDS));
   assign w_sizeBad = (r_size == 2'b11);

`ifdef DMEM_MISALIGN_TRAP_EN
   assign w_misalign = ((r_size == 2'b01) && r_addr[0]) ||
                       ((r_size == 2'b10) && (r_addr[1:0] != 2'b00));
`else
   assign w_misalign = 1'b0;
`endif

   assign w_err     = w_oob || w_sizeBad || w_misalign;
   assign w_idx     = r_addr[AW+1:2];
   assign w_memWord = r_mem[w_idx];

   always_comb begin
      w_offs     = r_addr[1:0];
      w_byteEn   = 4'b0000;
      w_laneData = r_wdata;
      case (r_size)
         2'b00: begin
            w_offs     = r_addr[1:0];
            w_byteEn   = 4'b0001 << r_addr[1:0];
            w_laneData = {4{r_wdata[7:0]}};
         end
         2'b01: begin
            w_offs     = {r_addr[1], 1'b0};
            w_byteEn   = r_addr[1] ? 4'b1100 : 4'b0011;
            w_laneData = {2{r_wdata[15:0]}};
         end
         2'b10: begin
            w_offs     = 2'b00;
            w_byteEn   = 4'b1111;
            w_laneData = r_wdata;
         end
         default: begin
            w_offs     = r_addr[1:0];
            w_byteEn   = 4'b0000;
            w_laneData = r_wdata;
         end
      endcase
   end

   // Shift the addressed lane down to bit 0, then extend by size and signedness.
   assign w_shifted = w_memWord >> {w_offs, 3'b000};

   always_comb begin
      w_loadData = 32'd0;
      case (r_size)
         2'b00:   w_loadData = r_unsigned ? {24'd0, w_shifted[7:0]}
                                          : {{24{w_shifted[7]}}, w_shifted[7:0]};
         2'b01:   w_loadData = r_unsigned ? {16'd0, w_shifted[15:0]}
                                          : {{16{w_shifted[15]}}, w_shifted[15:0]};
         2'b10:   w_loadData = w_memWord;
         default: w_loadData = 32'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      req_ready   = 1'b0;
      resp_valid  = 1'b0;
      resp_rdata  = 32'd0;
      resp_err    = 1'b0;
      case (r_state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               w_nextState = BUSY;
            end
         end
         BUSY: begin
            if (r_cnt == 4'd0) begin
               w_nextState = RESP;
            end
         end
         RESP: begin
            resp_valid = 1'b1;
            resp_rdata = r_rdata;
            resp_err   = r_err;
            if (resp_ready) begin
               w_nextState = IDLE;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt      <= 4'd0;
         r_we       <= 1'b0;
         r_size     <= 2'b00;
         r_unsigned <= 1'b0;
         r_addr     <= 32'd0;
         r_wdata    <= 32'd0;
         r_rdata    <= 32'd0;
         r_err      <= 1'b0;
      end else begin
         if (w_accept) begin
            r_we       <= req_we;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            r_cnt      <= CNT_INIT;
         end else if ((r_state == BUSY) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
         end

         if (w_done) begin
            r_err   <= w_err;
            r_rdata <= (w_err || r_we) ? 32'd0 : w_loadData;
         end else if (w_release) begin
            r_err   <= 1'b0;
            r_rdata <= 32'd0;
         end
      end
   end

   // Storage has no reset; a reset on the would-be write edge suppresses the store.
   always_ff @(posedge clk) begin
      if (!rst && w_done && r_we && !w_err) begin
         for (int i = 0; i < 4; i++) begin
            if (w_byteEn[i]) begin
               r_mem[w_idx][8*i +: 8] <= w_laneData[8*i +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder at LATENCY=2, DEPTH_WORDS=256.
// Expectations for the misaligned half load follow whether DMEM_MISALIGN_TRAP_EN is defined.
module tb_data_mem_responder;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;

   int testsRun;
   int testsFailed;

   data_mem_responder #(
      .DEPTH_WORDS(256),
      .LATENCY(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_we(req_we),
      .req_size(req_size),
      .req_unsigned(req_unsigned),
      .req_addr(req_addr),
      .req_wdata(req_wdata),
      .resp_valid(resp_valid),
      .resp_ready(resp_ready),
      .resp_rdata(resp_rdata),
      .resp_err(resp_err)
   );

   // Free-running clock; the bench drives and samples on the falling edge.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Issues one request with resp_ready=1 and returns the cycles from acceptance to resp_valid.
   task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output int lat, output logic [31:0] rdata, output logic err);
      int guard;
      guard = 0;
      while (!req_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      req_valid    = 1'b1;
      req_we       = we;
      req_size     = size;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wdata;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      lat = 0;
      while (!resp_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      if (!resp_valid) begin
         lat = -1;
      end
      rdata = resp_rdata;
      err   = resp_err;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      testsRun++;
      if (req_ready !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL reset_req_ready: got %b expected 1", req_ready);
      end
      testsRun++;
      if (resp_valid !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL reset_resp_valid: got %b expected 0", resp_valid);
      end
      testsRun++;
      if (resp_err !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL reset_resp_err: got %b expected 0", resp_err);
      end
      testsRun++;
      if (resp_rdata !== 32'd0) begin
         testsFailed++;
         $display("[TB] FAIL reset_resp_rdata: got %h expected 00000000", resp_rdata);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_word();
      int lat;
      logic [31:0] rdata;
      logic err;
      applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat, rdata, err);
      testsRun++;
      if (lat !== 2) begin
         testsFailed++;
         $display("[TB] FAIL sw_latency: got %0d expected 2", lat);
      end
      testsRun++;
      if (err !== 1'b0 || rdata !== 32'd0) begin
         testsFailed++;
         $display("[TB] FAIL sw_resp: got err=%b rdata=%h expected err=0 rdata=00000000", err, rdata);
      end
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rdata, err);
      testsRun++;
      if (lat !== 2) begin
         testsFailed++;
         $display("[TB] FAIL lw_latency: got %0d expected 2", lat);
      end
      testsRun++;
      if (rdata !== 32'hDEADBEEF || err !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL lw_data: got %h err=%b expected deadbeef err=0", rdata, err);
      end
   endtask

   task automatic test_byte();
      int lat;
      logic [31:0] rdata;
      logic err;
      applyStimulus(1'b1, 2'b00, 1'b0, 32'h11, 32'h80, lat, rdata, err);
      testsRun++;
      if (err !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL sb_err: got %b expected 0", err);
      end
      applyStimulus(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, lat, rdata, err);
      testsRun++;
      if (rdata !== 32'hFFFFFF80) begin
         testsFailed++;
         $display("[TB] FAIL lb_sext: got %h expected ffffff80", rdata);
      end
      applyStimulus(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, lat, rdata, err);
      testsRun++;
      if (rdata !== 32'h00000080) begin
         testsFailed++;
         $display("[TB] FAIL lbu_zext: got %h expected 00000080", rdata);
      end
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rdata, err);
      testsRun++;
      if (rdata !== 32'hDEAD80EF) begin
         testsFailed++;
         $display("[TB] FAIL lw_after_sb: got %h expected dead80ef", rdata);
      end
   endtask

   task automatic test_half();
      int lat;
      logic [31:0] rdata;
      logic err;
      applyStimulus(1'b1, 2'b10, 1'b0, 32'h14, 32'h55AA66BB, lat, rdata, err);
      applyStimulus(1'b1, 2'b01, 1'b0, 32'h16, 32'h12348001, lat, rdata, err);
      testsRun++;
      if (err !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL sh_err: got %b expected 0", err);
      end
      applyStimulus(1'b0, 2'b01, 1'b0, 32'h16, 32'h0, lat, rdata, err);
      testsRun++;
      if (rdata !== 32'hFFFF8001) begin
         testsFailed++;
         $display("[TB] FAIL lh_sext: got %h expected ffff8001", rdata);
      end
      applyStimulus(1'b0, 2'b01, 1'b1, 32'h16, 32'h0, lat, rdata, err);
      testsRun++;
      if (rdata !== 32'h00008001) begin
         testsFailed++;
         $display("[TB] FAIL lhu_zext: got %h expected 00008001", rdata);
      end
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, lat, rdata, err);
      testsRun++;
      if (rdata !== 32'h800166BB) begin
         testsFailed++;
         $display("[TB] FAIL lw_after_sh: got %h expected 800166bb", rdata);
      end
   endtask

   task automatic test_backpressure();
      int guard;
      int lat;
      logic [31:0] rdata;
      logic err;
      resp_ready   = 1'b0;
      req_valid    = 1'b1;
      req_we       = 1'b0;
      req_size     = 2'b10;
      req_unsigned = 1'b0;
      req_addr     = 32'h10;
      req_wdata    = 32'h0;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      guard = 0;
      while (!resp_valid && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      testsRun++;
      if (resp_valid !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL bp_resp_timeout: got resp_valid=%b expected 1", resp_valid);
      end
      // A store presented while a response is pending must be ignored.
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_wdata = 32'h0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         testsRun++;
         if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEAD80EF || req_ready !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL bp_hold_%0d: got valid=%b rdata=%h ready=%b expected valid=1 rdata=dead80ef ready=0",
                     i, resp_valid, resp_rdata, req_ready);
         end
      end
      resp_ready = 1'b1;
      @(negedge clk);
      testsRun++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_rdata !== 32'd0) begin
         testsFailed++;
         $display("[TB] FAIL bp_release: got valid=%b ready=%b rdata=%h expected valid=0 ready=1 rdata=00000000",
                  resp_valid, req_ready, resp_rdata);
      end
      req_valid = 1'b0;
      req_we    = 1'b0;
      @(negedge clk);
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rdata, err);
      testsRun++;
      if (rdata !== 32'hDEAD80EF) begin
         testsFailed++;
         $display("[TB] FAIL bp_ignored_store: got %h expected dead80ef", rdata);
      end
   endtask

   task automatic test_errors();
      int lat;
      logic [31:0] rdata;
      logic err;
      applyStimulus(1'b1, 2'b10, 1'b0, 32'h0, 32'hCAFEF00D, lat, rdata, err);
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, lat, rdata, err);
      testsRun++;
      if (err !== 1'b1 || rdata !== 32'd0 || lat !== 2) begin
         testsFailed++;
         $display("[TB] FAIL oob_lw: got err=%b rdata=%h lat=%0d expected err=1 rdata=00000000 lat=2", err, rdata, lat);
      end
      applyStimulus(1'b1, 2'b10, 1'b0, 32'h400, 32'h12345678, lat, rdata, err);
      testsRun++;
      if (err !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL oob_sw_err: got %b expected 1", err);
      end
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, lat, rdata, err);
      testsRun++;
      if (rdata !== 32'hCAFEF00D || err !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL oob_no_write: got %h err=%b expected cafef00d err=0", rdata, err);
      end
      applyStimulus(1'b1, 2'b11, 1'b0, 32'h0, 32'h11111111, lat, rdata, err);
      testsRun++;
      if (err !== 1'b1 || rdata !== 32'd0) begin
         testsFailed++;
         $display("[TB] FAIL size11_sw: got err=%b rdata=%h expected err=1 rdata=00000000", err, rdata);
      end
      applyStimulus(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, lat, rdata, err);
      testsRun++;
      if (err !== 1'b1 || rdata !== 32'd0) begin
         testsFailed++;
         $display("[TB] FAIL size11_lw: got err=%b rdata=%h expected err=1 rdata=00000000", err, rdata);
      end
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, lat, rdata, err);
      testsRun++;
      if (rdata !== 32'hCAFEF00D) begin
         testsFailed++;
         $display("[TB] FAIL size11_no_write: got %h expected cafef00d", rdata);
      end
   endtask

   task automatic test_misalign();
      int lat;
      logic [31:0] rdata;
      logic err;
      applyStimulus(1'b0, 2'b01, 1'b0, 32'h13, 32'h0, lat, rdata, err);
`ifdef DMEM_MISALIGN_TRAP_EN
      testsRun++;
      if (err !== 1'b1 || rdata !== 32'd0) begin
         testsFailed++;
         $display("[TB] FAIL lh_misalign: got err=%b rdata=%h expected err=1 rdata=00000000", err, rdata);
      end
`else
      testsRun++;
      if (err !== 1'b0 || rdata !== 32'hFFFFDEAD) begin
         testsFailed++;
         $display("[TB] FAIL lh_misalign: got err=%b rdata=%h expected err=0 rdata=ffffdead", err, rdata);
      end
`endif
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, lat, rdata, err);
`ifdef DMEM_MISALIGN_TRAP_EN
      testsRun++;
      if (err !== 1'b1 || rdata !== 32'd0) begin
         testsFailed++;
         $display("[TB] FAIL lw_misalign: got err=%b rdata=%h expected err=1 rdata=00000000", err, rdata);
      end
`else
      testsRun++;
      if (err !== 1'b0 || rdata !== 32'hDEAD80EF) begin
         testsFailed++;
         $display("[TB] FAIL lw_misalign: got err=%b rdata=%h expected err=0 rdata=dead80ef", err, rdata);
      end
`endif
   endtask

   task automatic test_reset_abort();
      int lat;
      logic [31:0] rdata;
      logic err;
      applyStimulus(1'b1, 2'b10, 1'b0, 32'h20, 32'hA5A5A5A5, lat, rdata, err);
      req_valid    = 1'b1;
      req_we       = 1'b1;
      req_size     = 2'b10;
      req_unsigned = 1'b0;
      req_addr     = 32'h20;
      req_wdata    = 32'h1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      rst       = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      testsRun++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL abort_idle: got ready=%b valid=%b expected ready=1 valid=0", req_ready, resp_valid);
      end
      repeat (4) @(negedge clk);
      testsRun++;
      if (resp_valid !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL abort_no_resp: got %b expected 0", resp_valid);
      end
      applyStimulus(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, lat, rdata, err);
      testsRun++;
      if (rdata !== 32'hA5A5A5A5) begin
         testsFailed++;
         $display("[TB] FAIL abort_no_write: got %h expected a5a5a5a5", rdata);
      end
   endtask

   initial begin
      testsRun     = 0;
      testsFailed  = 0;
      rst          = 1'b1;
      req_valid    = 1'b0;
      req_we       = 1'b0;
      req_size     = 2'b00;
      req_unsigned = 1'b0;
      req_addr     = 32'd0;
      req_wdata    = 32'd0;
      resp_ready   = 1'b1;
      @(negedge clk);
      test_reset();
      test_word();
      test_byte();
      test_half();
      test_backpressure();
      test_errors();
      test_misalign();
      test_reset_abort();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
